mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers for the MIPS32 core; generalises funct decode to
//  the MULT/DIV/MFHI/MFLO/MTHI/MTLO group. Sits beside the ALU in EX: the core presents R-type funct and

---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Core <-> multiply/divide unit bus: R-type funct/operands in, HI/LO, result and status out.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, funct, src_a, src_b, flush,
    input  rdata, busy, stall, done, div_zero, hi, lo
  );

  modport slave (
    input  op_valid, funct, src_a, src_b, flush,
    output rdata, busy, stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS32 multiply/divide unit: shift-add multiply, restoring divide on magnitudes,
// signs applied in a final fix-up cycle, architectural HI/LO with MFHI/MFLO/MTHI/MTLO.
module mult_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  mult_div_unit_if.slave md
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_div_zero;

  logic [WIDTH-1:0]     r_ph;
  logic [WIDTH-1:0]     r_pl;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_a_raw;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic                 r_is_div;
  logic                 r_b_zero;

  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_is_md;
  logic                 w_sgn;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic                 w_accept;
  logic                 w_mt_wr;
  logic                 w_last;
  logic                 w_commit;
  logic [WIDTH:0]       w_msum;
  logic [WIDTH:0]       w_dshift;
  logic [WIDTH:0]       w_dtrial;
  logic                 w_dge;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_dw(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_is_mul = (md.funct == F_MULT) || (md.funct == F_MULTU);
  assign w_is_div = (md.funct == F_DIV)  || (md.funct == F_DIVU);
  assign w_is_md  = w_is_mul || w_is_div ||
                    (md.funct == F_MFHI) || (md.funct == F_MFLO) ||
                    (md.funct == F_MTHI) || (md.funct == F_MTLO);
  assign w_sgn    = SIGNED_EN && ((md.funct == F_MULT) || (md.funct == F_DIV));
  assign w_neg_a  = w_sgn && md.src_a[WIDTH-1];
  assign w_neg_b  = w_sgn && md.src_b[WIDTH-1];

  assign w_accept = (r_state == S_IDLE) && md.op_valid && (w_is_mul || w_is_div) && !md.flush;
  assign w_mt_wr  = (r_state == S_IDLE) && md.op_valid &&
                    ((md.funct == F_MTHI) || (md.funct == F_MTLO));
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));
  assign w_commit = (r_state == S_FIX) && !md.flush;

  // Multiply step: conditionally add multiplicand into the high half, shift the pair right.
  assign w_msum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  // Divide step: shift next dividend bit into the remainder, subtract if it fits.
  assign w_dshift = {r_ph, r_pl[WIDTH-1]};
  assign w_dtrial = w_dshift - {1'b0, r_b};
  assign w_dge    = ~w_dtrial[WIDTH];
  assign w_prod   = {r_ph, r_pl};

  always_comb begin
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (!r_is_div) begin
      {w_fix_hi, w_fix_lo} = apply_sign_dw(w_prod, r_neg_a ^ r_neg_b);
    end else if (r_b_zero) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = '1;
    end else begin
      w_fix_lo = apply_sign_w(r_pl, r_neg_a ^ r_neg_b);
      w_fix_hi = apply_sign_w(r_ph, r_neg_a);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_is_mul ? S_MUL : S_DIV;
      S_MUL,
      S_DIV: begin
        if (md.flush)   w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= w_commit;
      r_div_zero <= w_commit && r_is_div && r_b_zero;
      if (w_accept)
        r_cnt <= '0;
      else if ((r_state == S_MUL) || (r_state == S_DIV))
        r_cnt <= r_cnt + 1'b1;
      if (w_commit) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (w_mt_wr) begin
        if (md.funct == F_MTHI) r_hi <= md.src_a;
        else                    r_lo <= md.src_a;
      end
    end
  end

  // Iteration datapath; contents are only meaningful between accept and commit.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_raw  <= md.src_a;
      r_neg_a  <= w_neg_a;
      r_neg_b  <= w_neg_b;
      r_is_div <= w_is_div;
      r_b_zero <= (md.src_b == '0);
      r_b      <= apply_sign_w(md.src_b, w_neg_b);
      r_ph     <= '0;
      r_pl     <= apply_sign_w(md.src_a, w_neg_a);
    end else if (r_state == S_MUL) begin
      r_ph <= w_msum[WIDTH:1];
      r_pl <= {w_msum[0], r_pl[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      r_ph <= w_dge ? w_dtrial[WIDTH-1:0] : w_dshift[WIDTH-1:0];
      r_pl <= {r_pl[WIDTH-2:0], w_dge};
    end
  end

  assign md.rdata    = (md.funct == F_MFHI) ? r_hi :
                       (md.funct == F_MFLO) ? r_lo : '0;
  assign md.busy     = (r_state != S_IDLE);
  assign md.stall    = md.busy && md.op_valid && w_is_md;
  assign md.done     = r_done;
  assign md.div_zero = r_div_zero;
  assign md.hi       = r_hi;
  assign md.lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random MULT/DIV traffic against a plain-arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clk = 1'b0;
  logic rst_n;

  mult_div_unit_if #(.WIDTH(W)) bus();

  mult_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   n_push = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p;
    logic [63:0] pu;
    int          sa;
    int          sb;
    e = '0;
    sa = a;
    sb = b;
    case (f)
      F_MULT: begin
        p = longint'(sa) * longint'(sb);
        {e.hi, e.lo} = p;
      end
      F_MULTU: begin
        pu = {32'b0, a} * {32'b0, b};
        {e.hi, e.lo} = pu;
      end
      F_DIV: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a; e.hi = '0;
        end else begin
          e.lo = sa / sb;
          e.hi = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("sb_hi", bus.hi, e.hi);
        chk("sb_lo", bus.lo, e.lo);
        chk("sb_div_zero", bus.div_zero, e.dz);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    bus.op_valid = 1'b0;
    bus.funct    = 6'b0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) return;
      @(posedge clk); #1;
    end
    chk({nm, "_timeout"}, bus.busy, 0);
  endtask

  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit track);
    wait_idle("start");
    bus.op_valid = 1'b1;
    bus.funct    = f;
    bus.src_a    = a;
    bus.src_b    = b;
    @(posedge clk);
    if (track) begin
      sb_q.push_back(ref_model(f, a, b));
      n_push++;
    end
    #1;
    idle_bus();
    chk("accept_busy", bus.busy, 1);
  endtask

  task automatic mt_write(input logic [5:0] f, input logic [31:0] v, input logic fl);
    wait_idle("mt");
    bus.op_valid = 1'b1;
    bus.funct    = f;
    bus.src_a    = v;
    bus.flush    = fl;
    @(posedge clk); #1;
    idle_bus();
  endtask

  initial begin
    exp_t        e;
    int          nbusy;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic [5:0]  f;

    idle_bus();
    rst_n = 1'b0;
    bus.op_valid = 1'b1;
    bus.funct    = F_MFHI;
    @(posedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_div_zero", bus.div_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_rdata", bus.rdata, 0);
    idle_bus();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed multiply with exact busy window and done pulse.
    start_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      nbusy++;
      chk("mul_done_early", bus.done, 0);
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", nbusy, 33);
    chk("mul_done_pulse", bus.done, 1);
    chk("mul_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mul_lo", bus.lo, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    chk("mul_done_once", bus.done, 0);

    start_op(F_DIVU, 32'd100, 32'd7, 1'b1);
    wait_idle("divu");
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    start_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div");
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    start_op(F_DIV, 32'd5, 32'd0, 1'b1);
    wait_idle("div0");
    chk("div0_flag", bus.div_zero, 1);
    chk("div0_done", bus.done, 1);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'd5);

    start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle("divovf");
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'd0);
    chk("divovf_flag", bus.div_zero, 0);

    // MFLO issued mid-multiply stalls until the done cycle, then shows the new LO.
    a = $urandom; b = $urandom;
    e = ref_model(F_MULT, a, b);
    start_op(F_MULT, a, b, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    bus.op_valid = 1'b1;
    bus.funct    = F_MFLO;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.busy) break;
      chk("mflo_stall", bus.stall, 1);
      @(posedge clk);
    end
    chk("mflo_stall_release", bus.stall, 0);
    chk("mflo_rdata", bus.rdata, e.lo);
    chk("mflo_done", bus.done, 1);
    @(posedge clk); #1;
    idle_bus();

    // Flush mid-divide; MT* attempted while busy must have no effect.
    mt_write(F_MTHI, 32'hA5A5_1234, 1'b0);
    mt_write(F_MTLO, 32'h5A5A_4321, 1'b0);
    old_hi = 32'hA5A5_1234;
    old_lo = 32'h5A5A_4321;
    chk("mthi_val", bus.hi, old_hi);
    chk("mtlo_val", bus.lo, old_lo);
    start_op(F_DIVU, $urandom, $urandom_range(1, 1000), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.op_valid = 1'b1;
    bus.funct    = F_MTHI;
    bus.src_a    = 32'hDEAD_BEEF;
    #1;
    chk("mt_busy_stall", bus.stall, 1);
    repeat (2) @(posedge clk);
    #1;
    idle_bus();
    repeat (5) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_hi", bus.hi, old_hi);
    chk("flush_lo", bus.lo, old_lo);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hi_late", bus.hi, old_hi);

    // flush beats start in IDLE; MT* proceeds despite flush.
    bus.op_valid = 1'b1;
    bus.funct    = F_MULT;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd3;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    chk("flush_start_busy", bus.busy, 0);
    mt_write(F_MTLO, 32'h0BAD_F00D, 1'b1);
    chk("mt_flush_lo", bus.lo, 32'h0BAD_F00D);

    // Async reset in the middle of a multiply.
    start_op(F_MULT, $urandom, $urandom, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mt_write(F_MTHI, 32'h0000_1234, 1'b0);
    bus.op_valid = 1'b1;
    bus.funct    = F_MFHI;
    #1;
    chk("mthi_after_rst", bus.hi, 32'h0000_1234);
    chk("mfhi_rdata", bus.rdata, 32'h0000_1234);
    idle_bus();
    @(posedge clk); #1;

    // Random back-to-back traffic with corner operands.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       f = F_MULT;
        1:       f = F_MULTU;
        2:       f = F_DIV;
        default: f = F_DIVU;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      start_op(f, a, b, 1'b1);
      if (n == 5) begin
        bus.op_valid = 1'b1;
        bus.funct    = F_ADD;
        #1;
        chk("nonmd_stall", bus.stall, 0);
        chk("nonmd_rdata", bus.rdata, 0);
        idle_bus();
      end
    end
    wait_idle("final");
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", sb_q.size(), 0);
    chk("done_count", n_done, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
